// File: rtl/mips_pkg.sv
// Shared definitions for the non-pipelined MIPS core: fetch FSM states,
// opcode constants used by fetch and control, and the default reset PC.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sign-extended, word-scaled beq displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read channel: req/addr from fetch, ack/rdata from memory.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/next_pc_calc.sv
// Next-PC selection after an instruction completes: jump, taken beq, or
// fall-through, in that priority order. All adds wrap modulo 2^32.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        jump,
  input  logic        branch,
  input  logic        alu_zero,
  output logic [31:0] next_pc
);

  // The opcode field is decoded by the control unit, not here.
  logic unused_opcode;
  assign unused_opcode = ^instr[31:26];

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (branch && alu_zero) begin
      next_pc = pc_plus4 + branch_offset(instr[15:0]);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch/PC sequencing stage: IDLE -> FETCH (req/ack) -> EXEC (wait for the
// datapath), then advance the PC and count the retired instruction.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  imem,
  input  logic          jump,
  input  logic          branch,
  input  logic          alu_zero,
  input  logic          stall,
  output logic [31:0]   instr,
  output logic [5:0]    opcode,
  output logic          instr_valid,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus4,
  output logic [31:0]   retired
);

  fetch_state_t state_reg;
  logic [31:0]  pc_reg;
  logic [31:0]  instr_reg;
  logic [31:0]  retired_reg;
  logic         req_reg;
  logic         valid_reg;
  logic [31:0]  pc_plus4_next;
  logic [31:0]  pc_next;

  assign pc_plus4_next = pc_reg + 32'd4;

  next_pc_calc u_next_pc_calc (
    .pc_plus4 (pc_plus4_next),
    .instr    (instr_reg),
    .jump     (jump),
    .branch   (branch),
    .alu_zero (alu_zero),
    .next_pc  (pc_next)
  );

  // req/valid are registered alongside the state so they never glitch;
  // imem_addr is the PC register itself, hence stable across wait states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      pc_reg      <= RESET_PC;
      instr_reg   <= 32'd0;
      retired_reg <= 32'd0;
      req_reg     <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          state_reg <= S_FETCH;
          req_reg   <= 1'b1;
        end
        S_FETCH: begin
          if (imem.imem_ack) begin
            instr_reg <= imem.imem_rdata;
            state_reg <= S_EXEC;
            req_reg   <= 1'b0;
            valid_reg <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            pc_reg      <= pc_next;
            retired_reg <= retired_reg + 32'd1;
            state_reg   <= S_FETCH;
            req_reg     <= 1'b1;
            valid_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          req_reg   <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_reg;
  assign imem.imem_addr = pc_reg;
  assign instr          = instr_reg;
  assign opcode         = instr_reg[31:26];
  assign instr_valid    = valid_reg;
  assign pc             = pc_reg;
  assign pc_plus4       = pc_plus4_next;
  assign retired        = retired_reg;

endmodule
